// File: rtl/afe_seq_ctrl.sv
// AFE4490 sequencer: writes the config table, then reads one LED/ambient frame per ADC_RDY edge.
// Optional feature macro AMB_SUB_EN adds registered LED-minus-ambient outputs.
module afe_seq_ctrl #(
  parameter int N_CFG       = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_init,
  input  logic        i_adc_rdy,
  output logic [7:0]  o_cfg_idx,
  input  logic [7:0]  i_cfg_addr,
  input  logic [23:0] i_cfg_data,
  output logic [7:0]  o_spi_addr,
  output logic [23:0] o_spi_wr_data,
  output logic        o_spi_rd_wr,
  output logic        o_spi_dv,
  input  logic        i_spi_done,
  input  logic [23:0] i_spi_rd_data,
  output logic [23:0] o_led2,
  output logic [23:0] o_aled2,
  output logic [23:0] o_led1,
  output logic [23:0] o_aled1,
  output logic        o_sample_valid,
  output logic        o_cfg_done,
  output logic        o_busy,
  output logic        o_overrun,
`ifdef AMB_SUB_EN
  output logic [23:0] o_led2_sub,
  output logic [23:0] o_led1_sub,
`endif
  output logic        o_err
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CFG_ISSUE = 3'd1;
  localparam logic [2:0] ST_CFG_WAIT  = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FR_ISSUE  = 3'd4;
  localparam logic [2:0] ST_FR_WAIT   = 3'd5;
  localparam logic [2:0] ST_PUBLISH   = 3'd6;

  localparam int         CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [7:0] LAST_IDX = 8'(N_CFG - 1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [2:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adc_prev_q;
  logic             cfg_done_q, cfg_done_d;
  logic             err_q, err_d;
  logic             ovr_q, ovr_d;
  logic [23:0]      sh_led2_q, sh_led2_d, sh_aled2_q, sh_aled2_d;
  logic [23:0]      sh_led1_q, sh_led1_d, sh_aled1_q, sh_aled1_d;
  logic [23:0]      led2_q, led2_d, aled2_q, aled2_d, led1_q, led1_d, aled1_q, aled1_d;
`ifdef AMB_SUB_EN
  logic [23:0]      led2_sub_q, led2_sub_d, led1_sub_q, led1_sub_d;
`endif

  logic        adc_edge, timeout, in_cfg, in_fr;
  logic [7:0]  fr_addr;
  logic [23:0] fr_data;
  logic        fr_rd;

  assign adc_edge = i_adc_rdy & ~adc_prev_q;
  assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign in_cfg   = (state_q == ST_CFG_ISSUE) || (state_q == ST_CFG_WAIT);
  assign in_fr    = (state_q == ST_FR_ISSUE) || (state_q == ST_FR_WAIT);

  // Frame step 0 enables SPI_READ, steps 1..4 read the four result registers, step 5 disables it.
  always_comb begin
    fr_addr = 8'h00;
    fr_data = 24'h000000;
    fr_rd   = 1'b0;
    case (step_q)
      3'd0:    fr_data = 24'h000001;
      3'd1:    begin fr_addr = 8'h2A; fr_rd = 1'b1; end
      3'd2:    begin fr_addr = 8'h2B; fr_rd = 1'b1; end
      3'd3:    begin fr_addr = 8'h2C; fr_rd = 1'b1; end
      3'd4:    begin fr_addr = 8'h2D; fr_rd = 1'b1; end
      default: fr_data = 24'h000000;
    endcase
  end

  // Request fields are held from the ISSUE cycle until done because state, index and step are frozen.
  assign o_spi_addr     = in_cfg ? i_cfg_addr : (in_fr ? fr_addr : 8'h00);
  assign o_spi_wr_data  = in_cfg ? i_cfg_data : (in_fr ? fr_data : 24'h000000);
  assign o_spi_rd_wr    = in_fr & fr_rd;
  assign o_spi_dv       = (state_q == ST_CFG_ISSUE) || (state_q == ST_FR_ISSUE);
  assign o_busy         = in_cfg | in_fr;
  assign o_sample_valid = (state_q == ST_PUBLISH);
  assign o_cfg_idx      = idx_q;
  assign o_cfg_done     = cfg_done_q;
  assign o_err          = err_q;
  assign o_overrun      = ovr_q;
  assign o_led2         = led2_q;
  assign o_aled2        = aled2_q;
  assign o_led1         = led1_q;
  assign o_aled1        = aled1_q;
`ifdef AMB_SUB_EN
  assign o_led2_sub     = led2_sub_q;
  assign o_led1_sub     = led1_sub_q;
`endif

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    cfg_done_d = cfg_done_q;
    err_d      = err_q;
    ovr_d      = ovr_q;
    sh_led2_d  = sh_led2_q;
    sh_aled2_d = sh_aled2_q;
    sh_led1_d  = sh_led1_q;
    sh_aled1_d = sh_aled1_q;
    led2_d     = led2_q;
    aled2_d    = aled2_q;
    led1_d     = led1_q;
    aled1_d    = aled1_q;
`ifdef AMB_SUB_EN
    led2_sub_d = led2_sub_q;
    led1_sub_d = led1_sub_q;
`endif

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (i_init) begin
          state_d    = ST_CFG_ISSUE;
          idx_d      = 8'd0;
          cfg_done_d = 1'b0;
          err_d      = 1'b0;
          ovr_d      = 1'b0;
        end else if (state_q == ST_RUN && adc_edge) begin
          state_d = ST_FR_ISSUE;
          step_d  = 3'd0;
        end
      end
      // The strobe cycle counts as cycle 0 of the wait, so the timeout lands TIMEOUT_CYC cycles after dv.
      ST_CFG_ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_CFG_WAIT;
      end
      ST_FR_ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_FR_WAIT;
      end
      ST_CFG_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_spi_done) begin
          if (idx_q == LAST_IDX) begin
            state_d    = ST_RUN;
            cfg_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_CFG_ISSUE;
          end
        end else if (timeout) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          cfg_done_d = 1'b0;
        end
      end
      ST_FR_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_spi_done) begin
          case (step_q)
            3'd1:    sh_led2_d  = i_spi_rd_data;
            3'd2:    sh_aled2_d = i_spi_rd_data;
            3'd3:    sh_led1_d  = i_spi_rd_data;
            3'd4:    sh_aled1_d = i_spi_rd_data;
            default: ;
          endcase
          if (step_q == 3'd5) begin
            state_d = ST_PUBLISH;
            led2_d  = sh_led2_q;
            aled2_d = sh_aled2_q;
            led1_d  = sh_led1_q;
            aled1_d = sh_aled1_q;
`ifdef AMB_SUB_EN
            led2_sub_d = sh_led2_q - sh_aled2_q;
            led1_sub_d = sh_led1_q - sh_aled1_q;
`endif
          end else begin
            step_d  = step_q + 3'd1;
            state_d = ST_FR_ISSUE;
          end
        end else if (timeout) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          cfg_done_d = 1'b0;
        end
      end
      ST_PUBLISH: state_d = ST_RUN;
      default:    state_d = ST_IDLE;
    endcase

    if (adc_edge && (in_fr || state_q == ST_PUBLISH)) ovr_d = 1'b1;
  end

  // NOTE: reset is synchronous, and state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 8'd0;
      step_q     <= 3'd0;
      cnt_q      <= '0;
      adc_prev_q <= 1'b0;
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      sh_led2_q  <= 24'd0;
      sh_aled2_q <= 24'd0;
      sh_led1_q  <= 24'd0;
      sh_aled1_q <= 24'd0;
      led2_q     <= 24'd0;
      aled2_q    <= 24'd0;
      led1_q     <= 24'd0;
      aled1_q    <= 24'd0;
`ifdef AMB_SUB_EN
      led2_sub_q <= 24'd0;
      led1_sub_q <= 24'd0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      adc_prev_q <= i_adc_rdy;
      cfg_done_q <= cfg_done_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
      sh_led2_q  <= sh_led2_d;
      sh_aled2_q <= sh_aled2_d;
      sh_led1_q  <= sh_led1_d;
      sh_aled1_q <= sh_aled1_d;
      led2_q     <= led2_d;
      aled2_q    <= aled2_d;
      led1_q     <= led1_d;
      aled1_q    <= aled1_d;
`ifdef AMB_SUB_EN
      led2_sub_q <= led2_sub_d;
      led1_sub_q <= led1_sub_d;
`endif
    end
  end

endmodule

// File: tb/tb_afe_seq_ctrl.sv
// Directed bench for afe_seq_ctrl: config sequence, frame reads, overrun, timeout and reset recovery.
// The SPI master is a small behavioural responder with a fixed 10-cycle latency.
module tb_afe_seq_ctrl;

  localparam int N_CFG    = 3;
  localparam int TMO      = 16;
  localparam int RESP_LAT = 10;

  logic        clk = 1'b0;
  logic        rst_n, init, adc_rdy;
  logic [7:0]  cfg_idx, cfg_addr, spi_addr;
  logic [23:0] cfg_data, spi_wr_data, spi_rd_data;
  logic        spi_rd_wr, spi_dv, spi_done, force_done;
  logic [23:0] led2, aled2, led1, aled1;
  logic        sample_valid, cfg_done, busy, overrun, err;
`ifdef AMB_SUB_EN
  logic [23:0] led2_sub, led1_sub;
`endif

  always #5 clk = ~clk;

  // External config table: address 0x40+idx, data 0xC0DE00+idx.
  assign cfg_addr = 8'h40 + cfg_idx;
  assign cfg_data = {16'hC0DE, cfg_idx};

  afe_seq_ctrl #(.N_CFG(N_CFG), .TIMEOUT_CYC(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init(init), .i_adc_rdy(adc_rdy),
    .o_cfg_idx(cfg_idx), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
    .o_spi_addr(spi_addr), .o_spi_wr_data(spi_wr_data), .o_spi_rd_wr(spi_rd_wr),
    .o_spi_dv(spi_dv), .i_spi_done(spi_done | force_done), .i_spi_rd_data(spi_rd_data),
    .o_led2(led2), .o_aled2(aled2), .o_led1(led1), .o_aled1(aled1),
    .o_sample_valid(sample_valid), .o_cfg_done(cfg_done), .o_busy(busy),
    .o_overrun(overrun),
`ifdef AMB_SUB_EN
    .o_led2_sub(led2_sub), .o_led1_sub(led1_sub),
`endif
    .o_err(err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, done_cyc = 0, dv_cnt = 0, sv_cnt = 0, n_tx = 0;
  logic        resp_en = 1'b0;
  logic [7:0]  log_addr [16];
  logic [23:0] log_data [16];
  logic        log_rw   [16];
  logic [23:0] v2a, v2b, v2c, v2d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;
  always @(negedge clk) if (spi_dv) dv_cnt++;
  always @(negedge clk) if (sample_valid) sv_cnt++;

  function automatic logic [23:0] rd_value(input logic [7:0] a);
    case (a)
      8'h2A:   return v2a;
      8'h2B:   return v2b;
      8'h2C:   return v2c;
      8'h2D:   return v2d;
      default: return 24'hDEAD00;
    endcase
  endfunction

  // Behavioural SPI master: logs each strobe, answers RESP_LAT cycles later, aborts on reset.
  initial begin
    logic aborted;
    logic [7:0] a;
    spi_done = 1'b0;
    spi_rd_data = 24'd0;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (spi_dv && resp_en && rst_n) begin
        a = spi_addr;
        if (n_tx < 16) begin
          log_addr[n_tx] = spi_addr;
          log_data[n_tx] = spi_wr_data;
          log_rw[n_tx]   = spi_rd_wr;
        end
        n_tx++;
        aborted = 1'b0;
        for (int i = 0; i < RESP_LAT; i++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted && resp_en) begin
          spi_done    = 1'b1;
          spi_rd_data = rd_value(a);
          done_cyc    = cyc;
        end
      end
    end
  end

  // Raises ADC_RDY, waits for the published frame and checks its SPI sequence and latency.
  task automatic run_frame(input string tag);
    logic [7:0]  ea [6];
    logic [23:0] ed [6];
    logic        er [6];
    logic        seen;
    ea = '{8'h00, 8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'h00};
    ed = '{24'h000001, 24'h0, 24'h0, 24'h0, 24'h0, 24'h000000};
    er = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    n_tx = 0; dv_cnt = 0; sv_cnt = 0;
    adc_rdy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sample_valid) begin seen = 1'b1; break; end
    end
    check({tag, "_sv_seen"}, seen, 1'b1);
    check({tag, "_publish_lat"}, cyc - done_cyc, 1);
    check({tag, "_n_tx"}, n_tx, 6);
    check({tag, "_dv_cycles"}, dv_cnt, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_addr%0d", tag, i), log_addr[i], ea[i]);
      check($sformatf("%s_rw%0d", tag, i), log_rw[i], er[i]);
      if (!er[i]) check($sformatf("%s_wdata%0d", tag, i), log_data[i], ed[i]);
    end
    check({tag, "_led2"}, led2, v2a);
    check({tag, "_aled2"}, aled2, v2b);
    check({tag, "_led1"}, led1, v2c);
    check({tag, "_aled1"}, aled1, v2d);
    @(negedge clk);
    check({tag, "_sv_one_cycle"}, sample_valid, 1'b0);
    adc_rdy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; init = 1'b0; adc_rdy = 1'b0; force_done = 1'b0;
    v2a = 24'h000111; v2b = 24'h000022; v2c = 24'h000333; v2d = 24'h000044;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_dv", spi_dv, 1'b0);
    check("rst_cfg_done", cfg_done, 1'b0);
    check("rst_idx", cfg_idx, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_led2", led2, 24'd0);
    check("rst_sv", sample_valid, 1'b0);

    // Reset while the second config write is outstanding.
    resp_en = 1'b1;
    init = 1'b1; @(negedge clk); init = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cfg_idx == 8'd1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("midcfg_idx1_seen", seen, 1'b1);
    repeat (3) @(negedge clk);
    check("midcfg_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midcfg_rst_dv", spi_dv, 1'b0);
    check("midcfg_rst_idx", cfg_idx, 8'd0);
    check("midcfg_rst_cfg_done", cfg_done, 1'b0);
    check("midcfg_rst_busy", busy, 1'b0);
    check("midcfg_rst_err", err, 1'b0);
    check("midcfg_rst_ovr", overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    // Full config sequence: three writes in index order.
    n_tx = 0; dv_cnt = 0;
    init = 1'b1; @(negedge clk); init = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cfg_done) begin seen = 1'b1; break; end
    end
    check("cfg_done_seen", seen, 1'b1);
    check("cfg_n_tx", n_tx, N_CFG);
    check("cfg_dv_cycles", dv_cnt, N_CFG);
    for (int i = 0; i < N_CFG; i++) begin
      check($sformatf("cfg_addr%0d", i), log_addr[i], 8'h40 + 8'(i));
      check($sformatf("cfg_data%0d", i), log_data[i], {16'hC0DE, 8'(i)});
      check($sformatf("cfg_rw%0d", i), log_rw[i], 1'b0);
    end
    check("cfg_busy_after", busy, 1'b0);
    check("cfg_err_after", err, 1'b0);

    // Frame with the reference read values.
    run_frame("f1");
    check("f1_ovr", overrun, 1'b0);
    check("f1_cfg_done", cfg_done, 1'b1);

    // Frame where ambient exceeds LED: subtraction wraps.
    v2a = 24'h000010; v2b = 24'h000020; v2c = 24'h000005; v2d = 24'h000003;
    run_frame("f2");
`ifdef AMB_SUB_EN
    check("f2_led2_sub", led2_sub, 24'hFFFFF0);
    check("f2_led1_sub", led1_sub, 24'h000002);
`endif

    // Second ADC_RDY edge while reading 0x2B: flagged and dropped.
    v2a = 24'h0A0A0A; v2b = 24'h0B0B0B; v2c = 24'h0C0C0C; v2d = 24'h0D0D0D;
    n_tx = 0; dv_cnt = 0; sv_cnt = 0;
    adc_rdy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (spi_dv && spi_addr == 8'h2B) begin seen = 1'b1; break; end
    end
    check("ovr_2b_seen", seen, 1'b1);
    adc_rdy = 1'b0; @(negedge clk);
    adc_rdy = 1'b1; @(negedge clk);
    adc_rdy = 1'b0;
    repeat (250) @(negedge clk);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_frames", sv_cnt, 1);
    check("ovr_n_tx", dv_cnt, 6);
    check("ovr_led1", led1, 24'h0C0C0C);
    check("ovr_cfg_done", cfg_done, 1'b1);

    // Timeout: master never answers.
    resp_en = 1'b0;
    init = 1'b1; @(negedge clk); init = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (spi_dv) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("tmo_dv_seen", seen, 1'b1);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_err_early", err, 1'b0);
    check("tmo_busy_early", busy, 1'b1);
    @(negedge clk);
    check("tmo_err", err, 1'b1);
    check("tmo_busy", busy, 1'b0);
    check("tmo_cfg_done", cfg_done, 1'b0);
    check("tmo_dv", spi_dv, 1'b0);

    // A late completion in IDLE changes nothing.
    force_done = 1'b1; @(negedge clk); force_done = 1'b0;
    @(negedge clk);
    check("late_done_busy", busy, 1'b0);
    check("late_done_err", err, 1'b1);
    check("late_done_cfg_done", cfg_done, 1'b0);
    check("late_done_idx", cfg_idx, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
